rv_datapath_core: RTL and testbench
===================================

Name: rv_datapath_core

Overview:
- Combinational/sequential datapath slice of the RISC-V softcore.
- Combines the instruction decoder, main ALU and word-addressed data memory into one block.
- Sits between the program counter/instruction memory and the register file.
- Takes a 32-bit instruction plus register-file read data; returns decoded fields, the ALU result and memory load data.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in data memory; power of two, 4..1024.

Ports:
- clk_i  in  1  clock; memory writes on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- instruction_i  in  32  instruction word.
- alu_control_i  in  3  ALU operation select.
- reg_data_1_i  in  32  rs1 value (ALU operand A).
- reg_data_2_i  in  32  rs2 value (R-type operand B, store data).
- mem_write_enable_i  in  1  data memory write strobe.
- opcode_o  out  7  instruction[6:0].
- funct3_o  out  3  instruction[14:12].
- funct7_o  out  7  instruction[31:25].
- rs1_o  out  5  instruction[19:15].
- rs2_o  out  5  instruction[24:20].
- rd_o  out  5  instruction[11:7].
- immediate_i_o / immediate_s_o / immediate_u_o / immediate_b_o / immediate_j_o  out  32 each  decoded immediates.
- alu_result_o  out  32  ALU result (also the data memory address).
- zero_o  out  1  high when alu_result_o == 0.
- mem_data_o  out  32  data memory read data.

Behaviour:
- Decode is purely combinational and always active; fields are derived regardless of opcode.
- Immediate formats, all sign-extended from instruction[31]:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}; no extension needed.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- ALU operand B select (combinational):
  - opcode 0100011 (store): immediate_s.
  - opcode 0110011 (R-type): reg_data_2_i.
  - Otherwise: immediate_i.
- ALU operations, all 32-bit with wrap-around and no overflow flag:
  - 000: AND.
  - 001: OR.
  - 010: ADD.
  - 110: SUB (A−B).
  - 111: SLT (signed compare; 1 or 0).
  - 100: XOR.
  - 101: SLL by B[4:0].
  - 011: result 0.
- Data memory:
  - MEM_WORDS×32 array, word-indexed by alu_result_o[log2(MEM_WORDS)+1:2].
  - Address bits [1:0] ignored; upper address bits ignored, so addresses wrap modulo memory size.
  - Read is asynchronous: mem_data_o follows the address combinationally.
  - Write: on rising clk_i when mem_write_enable_i=1 and reset_i=1, writes reg_data_2_i to the addressed word.
  - Read during a write cycle returns the old word until the edge, then the new word.
- Reset:
  - reset_i=0 asynchronously clears every memory word to 0 and blocks writes.
  - Consequently mem_data_o=0 while reset is held and immediately after release.
  - Decoder and ALU outputs are unaffected by reset (pure functions of inputs).
- No latency on any output except memory content updates, which take one clock edge.

Test Plan:
- Load decode: instruction 0xFFC4A303 → opcode 0000011, rd 6, rs1 9, funct3 010, immediate_i 0xFFFFFFFC; alu_control 010, reg_data_1 0x00000010 → alu_result 0x0000000C.
- Store/load: instruction 0x0064A423 → immediate_s 8, rs1 9, rs2 6. Then:
  - reg_data_1 0x20, reg_data_2 0xDEADBEEF, write enable, one edge → mem word 10 holds it.
  - Any instruction/reg_data_1 combination giving alu_result 0x28, with write enable low → mem_data_o 0xDEADBEEF.
- U/J decode:
  - 0x123452B7 → immediate_u 0x12345000, rd 5.
  - 0x008000EF → immediate_j 0x00000008, rd 1.
  - Force inst[31]=1 and confirm the J immediate is negative.
- ALU corners (R-type opcode):
  - 0x7FFFFFFF+1 → 0x80000000.
  - 5 SUB 7 → 0xFFFFFFFE.
  - SLT(−1, 1) → 1, zero_o 0.
  - 3 SUB 3 → zero_o 1.
- Reset mid-operation:
  - Write 0x1234 to address 0.
  - Assert reset_i low between edges → mem_data_o 0 immediately.
  - Writes during reset ignored; after release the word still reads 0.
- Address wrap: with MEM_WORDS=64, write at address 0x100 → readable at address 0x000; write at 0x003 → stored in word 0.

Source files
------------

// File: rtl/rv_datapath_core.sv
// rtl/rv_datapath_core.sv - decoder, ALU and word-addressed data memory slice of the RISC-V softcore
// Decode and ALU are pure functions of the inputs; only the data memory holds state.
module rv_datapath_core #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic [2:0]  alu_control_i,
  input  logic [31:0] reg_data_1_i,
  input  logic [31:0] reg_data_2_i,
  input  logic        mem_write_enable_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] immediate_i_o,
  output logic [31:0] immediate_s_o,
  output logic [31:0] immediate_u_o,
  output logic [31:0] immediate_b_o,
  output logic [31:0] immediate_j_o,
  output logic [31:0] alu_result_o,
  output logic        zero_o,
  output logic [31:0] mem_data_o
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  logic [31:0]   operand_b;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_q [MEM_WORDS];

  assign opcode_o = instruction_i[6:0];
  assign funct3_o = instruction_i[14:12];
  assign funct7_o = instruction_i[31:25];
  assign rs1_o    = instruction_i[19:15];
  assign rs2_o    = instruction_i[24:20];
  assign rd_o     = instruction_i[11:7];

  assign immediate_i_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign immediate_s_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign immediate_u_o = {instruction_i[31:12], 12'b0};
  assign immediate_b_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                          instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign immediate_j_o = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                          instruction_i[20], instruction_i[30:21], 1'b0};

  always_comb begin
    operand_b = immediate_i_o;
    if (opcode_o == OP_STORE) begin
      operand_b = immediate_s_o;
    end else if (opcode_o == OP_RTYPE) begin
      operand_b = reg_data_2_i;
    end
  end

  always_comb begin
    alu_result_o = 32'd0;
    case (alu_control_i)
      ALU_AND:  alu_result_o = reg_data_1_i & operand_b;
      ALU_OR:   alu_result_o = reg_data_1_i | operand_b;
      ALU_ADD:  alu_result_o = reg_data_1_i + operand_b;
      ALU_ZERO: alu_result_o = 32'd0;
      ALU_XOR:  alu_result_o = reg_data_1_i ^ operand_b;
      ALU_SLL:  alu_result_o = reg_data_1_i << operand_b[4:0];
      ALU_SUB:  alu_result_o = reg_data_1_i - operand_b;
      ALU_SLT:  alu_result_o = ($signed(reg_data_1_i) < $signed(operand_b)) ? 32'd1 : 32'd0;
      default:  alu_result_o = 32'd0;
    endcase
  end

  assign zero_o = (alu_result_o == 32'd0);

  // Byte-offset bits and bits above the array size are dropped, so addresses wrap.
  assign mem_idx = alu_result_o[AW+1:2];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_write_enable_i) begin
      mem_q[mem_idx] <= reg_data_2_i;
    end
  end

  assign mem_data_o = mem_q[mem_idx];

endmodule

// File: tb/tb_rv_datapath_core.sv
// tb/tb_rv_datapath_core.sv - directed vector bench for rv_datapath_core
module tb_rv_datapath_core;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] instruction_i;
  logic [2:0]  alu_control_i;
  logic [31:0] reg_data_1_i;
  logic [31:0] reg_data_2_i;
  logic        mem_write_enable_i;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [31:0] immediate_i_o;
  logic [31:0] immediate_s_o;
  logic [31:0] immediate_u_o;
  logic [31:0] immediate_b_o;
  logic [31:0] immediate_j_o;
  logic [31:0] alu_result_o;
  logic        zero_o;
  logic [31:0] mem_data_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  rv_datapath_core #(.MEM_WORDS(64)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .instruction_i(instruction_i),
    .alu_control_i(alu_control_i),
    .reg_data_1_i(reg_data_1_i),
    .reg_data_2_i(reg_data_2_i),
    .mem_write_enable_i(mem_write_enable_i),
    .opcode_o(opcode_o),
    .funct3_o(funct3_o),
    .funct7_o(funct7_o),
    .rs1_o(rs1_o),
    .rs2_o(rs2_o),
    .rd_o(rd_o),
    .immediate_i_o(immediate_i_o),
    .immediate_s_o(immediate_s_o),
    .immediate_u_o(immediate_u_o),
    .immediate_b_o(immediate_b_o),
    .immediate_j_o(immediate_j_o),
    .alu_result_o(alu_result_o),
    .zero_o(zero_o),
    .mem_data_o(mem_data_o)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] ctl,
                       input logic [31:0] a, input logic [31:0] b, input logic we);
    instruction_i      = instr;
    alu_control_i      = ctl;
    reg_data_1_i       = a;
    reg_data_2_i       = b;
    mem_write_enable_i = we;
    #1;
  endtask

  initial begin
    // R-type opcode 0x33 selects reg_data_2 as operand B; 0x13/0x03 use immediate_i.
    vecs[0]  = '{"add_wrap",  32'h00000033, 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{"sub_neg",   32'h00000033, 3'b110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"slt_true",  32'h00000033, 3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[3]  = '{"sub_zero",  32'h00000033, 3'b110, 32'd3,        32'd3,        32'd0,        1'b1};
    vecs[4]  = '{"and",       32'h00000033, 3'b000, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0};
    vecs[5]  = '{"or",        32'h00000033, 3'b001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
    vecs[6]  = '{"xor",       32'h00000033, 3'b100, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0};
    vecs[7]  = '{"sll_mask",  32'h00000033, 3'b101, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0};
    vecs[8]  = '{"op011",     32'h00000033, 3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    vecs[9]  = '{"slt_false", 32'h00000033, 3'b111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[10] = '{"load_addr", 32'hFFC4A303, 3'b010, 32'h00000010, 32'hFFFFFFFF, 32'h0000000C, 1'b0};

    reset_i = 1'b0;
    drive(32'h0, 3'b011, 32'h0, 32'h0, 1'b0);
    check("reset_mem", mem_data_o, 32'h0);
    tick();
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].instr, vecs[i].ctl, vecs[i].a, vecs[i].b, 1'b0);
      check({vecs[i].name, "_res"}, alu_result_o, vecs[i].res);
      check({vecs[i].name, "_zero"}, {31'd0, zero_o}, {31'd0, vecs[i].zero});
    end

    drive(32'hFFC4A303, 3'b010, 32'h10, 32'h0, 1'b0);
    check("ld_opcode", {25'd0, opcode_o}, 32'h03);
    check("ld_rd", {27'd0, rd_o}, 32'd6);
    check("ld_rs1", {27'd0, rs1_o}, 32'd9);
    check("ld_funct3", {29'd0, funct3_o}, 32'd2);
    check("ld_imm_i", immediate_i_o, 32'hFFFFFFFC);

    drive(32'h0064A423, 3'b010, 32'h20, 32'hDEADBEEF, 1'b1);
    check("st_imm_s", immediate_s_o, 32'd8);
    check("st_rs1", {27'd0, rs1_o}, 32'd9);
    check("st_rs2", {27'd0, rs2_o}, 32'd6);
    check("st_funct7", {25'd0, funct7_o}, 32'd0);
    check("st_addr", alu_result_o, 32'h28);
    check("st_old_word", mem_data_o, 32'h0);
    tick();
    check("st_new_word", mem_data_o, 32'hDEADBEEF);
    drive(32'h02800003, 3'b010, 32'h0, 32'h0, 1'b0);
    check("ld_back", mem_data_o, 32'hDEADBEEF);

    drive(32'h123452B7, 3'b011, 32'h0, 32'h0, 1'b0);
    check("u_imm", immediate_u_o, 32'h12345000);
    check("u_rd", {27'd0, rd_o}, 32'd5);
    drive(32'h008000EF, 3'b011, 32'h0, 32'h0, 1'b0);
    check("j_imm", immediate_j_o, 32'h00000008);
    check("j_rd", {27'd0, rd_o}, 32'd1);
    drive(32'h808000EF, 3'b011, 32'h0, 32'h0, 1'b0);
    check("j_imm_neg", immediate_j_o, 32'hFFF00008);
    drive(32'hFE000EE3, 3'b011, 32'h0, 32'h0, 1'b0);
    check("b_imm_neg", immediate_b_o, 32'hFFFFFFFC);

    // Reset asserted between edges clears memory at once and blocks writes.
    drive(32'h00000033, 3'b011, 32'h0, 32'h00001234, 1'b1);
    tick();
    drive(32'h00000033, 3'b011, 32'h0, 32'h0, 1'b0);
    check("rst_pre", mem_data_o, 32'h00001234);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("rst_now", mem_data_o, 32'h0);
    drive(32'h00000033, 3'b011, 32'h0, 32'h0000BEEF, 1'b1);
    tick();
    tick();
    check("rst_held", mem_data_o, 32'h0);
    mem_write_enable_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    tick();
    check("rst_after", mem_data_o, 32'h0);
    drive(32'h0064A423, 3'b010, 32'h20, 32'h0, 1'b0);
    check("rst_word10", mem_data_o, 32'h0);

    drive(32'h10000013, 3'b010, 32'h0, 32'h0000A5A5, 1'b1);
    check("wrap_addr", alu_result_o, 32'h100);
    tick();
    drive(32'h00000033, 3'b011, 32'h0, 32'h0, 1'b0);
    check("wrap_100", mem_data_o, 32'h0000A5A5);
    drive(32'h00300013, 3'b010, 32'h0, 32'h00005A5A, 1'b1);
    tick();
    drive(32'h00000033, 3'b011, 32'h0, 32'h0, 1'b0);
    check("wrap_003", mem_data_o, 32'h00005A5A);
    drive(32'h00400013, 3'b010, 32'h0, 32'h0, 1'b0);
    check("wrap_word1", mem_data_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
